// File: rtl/lsu_store_queue.sv
// lsu_store_queue: speculative + committed store FIFOs feeding dcache writes, with page-offset alias detection for loads.
module lsu_store_queue #(
    parameter int DEPTH_SPEC   = 4,
    parameter int DEPTH_COMMIT = 4,
    parameter int PLEN         = 56,
    parameter int DATA_W       = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                st_valid_i,
    output logic                st_ready_o,
    input  logic [PLEN-1:0]     st_paddr_i,
    input  logic [DATA_W-1:0]   st_data_i,
    input  logic [DATA_W/8-1:0] st_be_i,
    input  logic [1:0]          st_size_i,
    input  logic                commit_i,
    output logic                commit_ready_o,
    input  logic [11:0]         ld_page_offset_i,
    output logic                ld_match_o,
    output logic                no_st_pending_o,
    output logic                req_o,
    input  logic                gnt_i,
    output logic [PLEN-1:0]     req_paddr_o,
    output logic [DATA_W-1:0]   req_data_o,
    output logic [DATA_W/8-1:0] req_be_o,
    output logic [1:0]          req_size_o
);
    localparam int BE_W = DATA_W / 8;
    localparam int SW   = $clog2(DEPTH_SPEC);
    localparam int CW   = $clog2(DEPTH_COMMIT);

    typedef struct packed {
        logic [PLEN-1:0]   paddr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
        logic [1:0]        size;
    } entry_t;

    entry_t spec_q [DEPTH_SPEC];
    entry_t commit_q [DEPTH_COMMIT];
    logic [DEPTH_SPEC-1:0]   spec_valid;
    logic [DEPTH_COMMIT-1:0] commit_valid;
    logic [SW-1:0] spec_rptr, spec_wptr;
    logic [SW:0]   spec_cnt;
    logic [CW-1:0] commit_rptr, commit_wptr;
    logic [CW:0]   commit_cnt;
    logic push, commit, pop;
    logic unused_ok;

    assign st_ready_o      = spec_cnt < (SW+1)'(DEPTH_SPEC);
    assign commit_ready_o  = commit_cnt < (CW+1)'(DEPTH_COMMIT);
    assign req_o           = commit_cnt != '0;
    assign no_st_pending_o = (spec_cnt == '0) && (commit_cnt == '0);
    assign req_paddr_o     = commit_q[commit_rptr].paddr;
    assign req_data_o      = commit_q[commit_rptr].data;
    assign req_be_o        = commit_q[commit_rptr].be;
    assign req_size_o      = commit_q[commit_rptr].size;
    assign unused_ok       = ^ld_page_offset_i[2:0];

    // A push racing a flush is dropped; a commit racing a flush still moves the head.
    assign push   = st_valid_i && st_ready_o && !flush_i;
    assign commit = commit_i && commit_ready_o && (spec_cnt != '0);
    assign pop    = req_o && gnt_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            spec_rptr    <= '0;
            spec_wptr    <= '0;
            spec_cnt     <= '0;
            spec_valid   <= '0;
            commit_rptr  <= '0;
            commit_wptr  <= '0;
            commit_cnt   <= '0;
            commit_valid <= '0;
        end else begin
            if (flush_i) begin
                spec_rptr  <= '0;
                spec_wptr  <= '0;
                spec_cnt   <= '0;
                spec_valid <= '0;
            end else begin
                spec_rptr  <= commit ? spec_rptr + SW'(1) : spec_rptr;
                spec_wptr  <= push ? spec_wptr + SW'(1) : spec_wptr;
                spec_cnt   <= spec_cnt + (SW+1)'(push) - (SW+1)'(commit);
                spec_valid <= (spec_valid | (push ? DEPTH_SPEC'(1) << spec_wptr : '0))
                              & ~(commit ? DEPTH_SPEC'(1) << spec_rptr : '0);
            end
            commit_rptr  <= pop ? commit_rptr + CW'(1) : commit_rptr;
            commit_wptr  <= commit ? commit_wptr + CW'(1) : commit_wptr;
            commit_cnt   <= commit_cnt + (CW+1)'(commit) - (CW+1)'(pop);
            commit_valid <= (commit_valid | (commit ? DEPTH_COMMIT'(1) << commit_wptr : '0))
                            & ~(pop ? DEPTH_COMMIT'(1) << commit_rptr : '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            spec_q[spec_wptr] <= '{paddr: st_paddr_i, data: st_data_i, be: st_be_i, size: st_size_i};
        if (commit)
            commit_q[commit_wptr] <= spec_q[spec_rptr];
    end

    // Only registered valid bits count, so an entry being written this cycle never matches.
    always_comb begin
        ld_match_o = 1'b0;
        for (int i = 0; i < DEPTH_SPEC; i++)
            if (spec_valid[i] && spec_q[i].paddr[11:3] == ld_page_offset_i[11:3])
                ld_match_o = 1'b1;
        for (int i = 0; i < DEPTH_COMMIT; i++)
            if (commit_valid[i] && commit_q[i].paddr[11:3] == ld_page_offset_i[11:3])
                ld_match_o = 1'b1;
    end

    always @(posedge clk_i)
        if (!rst_i)
            assert (!(commit_i && spec_cnt == '0));
endmodule
